// File: rtl/debug_loader.sv
// debug_loader: receives a framed byte stream and writes its words into the core's
// instruction memory. A frame is a sync byte, a little-endian base address, a
// little-endian word count N, and then N little-endian data words. The core is held
// while a frame loads. Malformed headers raise a sticky error flag.
module debug_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [31:0] MAX_WORDS = 32'd4096
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        DEBUG_SIG,
    output logic [31:0] DEBUG_addr,
    output logic [31:0] DEBUG_instr,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        CNT   = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t      state_reg;
    logic [1:0]  byte_cnt_reg;
    // Only the three earlier bytes of a field need storing; the fourth comes
    // straight from rx_data in the cycle that completes the field.
    logic [23:0] shift_reg;
    logic [31:0] base_reg;
    logic [31:0] count_reg;
    logic [31:0] word_idx_reg;

    logic        accept;
    logic        last_byte;
    logic [31:0] field_word;
    logic        more_words;

    assign accept     = rx_valid && rx_ready;
    assign last_byte  = (byte_cnt_reg == 2'd3);
    // Newest byte goes on top, so after four bytes byte k sits at bits [8k+7:8k].
    assign field_word = {rx_data, shift_reg};
    // Evaluated one bit wider so the increment can never wrap the comparison.
    assign more_words = ({1'b0, word_idx_reg} + 33'd1) < {1'b0, count_reg};

    // Frame-parsing FSM; every output is a register updated on the state transition.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg    <= IDLE;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 24'd0;
            base_reg     <= 32'd0;
            count_reg    <= 32'd0;
            word_idx_reg <= 32'd0;
            rx_ready     <= 1'b0;
            DEBUG_SIG    <= 1'b0;
            DEBUG_addr   <= 32'd0;
            DEBUG_instr  <= 32'd0;
            core_hold    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            DEBUG_SIG <= 1'b0;
            load_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    rx_ready <= 1'b1;
                    if (accept && (rx_data == SYNC_BYTE)) begin
                        state_reg    <= ADDR;
                        byte_cnt_reg <= 2'd0;
                        load_err     <= 1'b0;
                        core_hold    <= 1'b1;
                    end
                end

                ADDR: begin
                    if (accept) begin
                        shift_reg    <= field_word[31:8];
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            if (field_word[1:0] != 2'b00) begin
                                // Base must be word aligned; abandon the frame.
                                load_err  <= 1'b1;
                                core_hold <= 1'b0;
                                state_reg <= IDLE;
                            end else begin
                                base_reg  <= field_word;
                                state_reg <= CNT;
                            end
                        end
                    end
                end

                CNT: begin
                    if (accept) begin
                        shift_reg    <= field_word[31:8];
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            if (field_word == 32'd0) begin
                                // Empty frame completes immediately.
                                rx_ready  <= 1'b0;
                                load_done <= 1'b1;
                                state_reg <= DONE;
                            end else if (field_word > MAX_WORDS) begin
                                load_err  <= 1'b1;
                                core_hold <= 1'b0;
                                state_reg <= IDLE;
                            end else begin
                                count_reg    <= field_word;
                                word_idx_reg <= 32'd0;
                                state_reg    <= DATA;
                            end
                        end
                    end
                end

                DATA: begin
                    if (accept) begin
                        shift_reg    <= field_word[31:8];
                        byte_cnt_reg <= byte_cnt_reg + 2'd1;
                        if (last_byte) begin
                            // Launch the write; address wraps modulo 2^32.
                            rx_ready    <= 1'b0;
                            DEBUG_SIG   <= 1'b1;
                            DEBUG_instr <= field_word;
                            DEBUG_addr  <= base_reg + {word_idx_reg[29:0], 2'b00};
                            state_reg   <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (more_words) begin
                        word_idx_reg <= word_idx_reg + 32'd1;
                        rx_ready     <= 1'b1;
                        state_reg    <= DATA;
                    end else begin
                        load_done <= 1'b1;
                        state_reg <= DONE;
                    end
                end

                DONE: begin
                    core_hold <= 1'b0;
                    rx_ready  <= 1'b1;
                    state_reg <= IDLE;
                end

                default: begin
                    core_hold <= 1'b0;
                    rx_ready  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/debug_loader.md
DEBUG_LOADER -- requirements
Module: debug_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: the start-of-frame marker.
REQ-002 SHALL have parameter MAX_WORDS, default 32'd4096: the largest legal word count per frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid, input, 1 bit: rx_data holds a valid byte.
REQ-006 SHALL have port rx_data, input, 8 bits: the incoming byte stream.
REQ-007 SHALL have port rx_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-008 SHALL have port DEBUG_SIG, output, 1 bit: instruction-memory write strobe to the core.
REQ-009 SHALL have port DEBUG_addr, output, 32 bits: write byte address.
REQ-010 SHALL have port DEBUG_instr, output, 32 bits: write data word.
REQ-011 SHALL have port core_hold, output, 1 bit: holds the core pipeline while a frame loads.
REQ-012 SHALL have port load_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-013 SHALL have port load_err, output, 1 bit: sticky frame-error flag.

Function
REQ-014 A byte SHALL be consumed only in a cycle where rx_valid && rx_ready are both high; rx_data SHALL be ignored otherwise.
REQ-015 Frame format SHALL be: SYNC_BYTE, 4-byte base address, 4-byte word count N, then N 4-byte data words; every multi-byte field is little-endian.
REQ-016 The FSM SHALL have states IDLE, ADDR, CNT, DATA, WRITE, DONE.
REQ-017 IDLE: rx_ready=1; a byte equal to SYNC_BYTE SHALL go to ADDR, clear load_err and set core_hold=1; any other byte SHALL be discarded and the FSM stays in IDLE.
REQ-018 ADDR and CNT: rx_ready=1; each state SHALL assemble 4 bytes using a 2-bit byte counter, then advance to the next state.
REQ-019 After the 4th ADDR byte: if base[1:0]!=0, the FSM SHALL set load_err, drop core_hold and go to IDLE.
REQ-020 After the 4th CNT byte: N==0 SHALL go to DONE; N>MAX_WORDS SHALL set load_err, drop core_hold and go to IDLE; otherwise the FSM SHALL go to DATA.
REQ-021 DATA: rx_ready=1; the 4th accepted byte of word i SHALL move the FSM to WRITE.
REQ-022 WRITE: SHALL last exactly 1 cycle with rx_ready=0, DEBUG_SIG=1, DEBUG_instr = the assembled word and DEBUG_addr = base + 4*i (modulo 2^32, wrapping silently).
REQ-023 From WRITE, the FSM SHALL go to DATA if i+1<N, otherwise to DONE; the word index i SHALL be 32 bits.
REQ-024 DONE: SHALL last 1 cycle with load_done=1 and rx_ready=0; core_hold SHALL go to 0 on the same clock edge that leaves DONE; the next state is IDLE.
REQ-025 DEBUG_SIG SHALL be 0 in every state except WRITE; DEBUG_addr and DEBUG_instr SHALL hold their last values outside WRITE.
REQ-026 Latency: DEBUG_SIG SHALL rise on the clock edge after the 4th byte of a word is accepted; load_done SHALL rise the cycle after the last WRITE, or the cycle after the 4th CNT byte when N==0.
REQ-027 A SYNC_BYTE value arriving mid-frame SHALL be treated as ordinary data; there is no resynchronisation inside a frame.
REQ-028 rx_valid deasserted mid-field SHALL stall the FSM with all partial bytes retained; there is no timeout.
REQ-029 Byte-lane assembly SHALL place byte k of a field at bits [8k+7:8k].

Reset
REQ-030 On nrst=0, asynchronously: state=IDLE; all counters and shift registers =0; DEBUG_SIG=0, DEBUG_addr=0, DEBUG_instr=0, core_hold=0, load_done=0, load_err=0, rx_ready=0.
REQ-031 rx_ready SHALL become 1 on the first clock edge after nrst deasserts.
REQ-032 Reset asserted mid-frame SHALL abandon the frame, with no further DEBUG_SIG pulses after reset releases.

Verification
REQ-033 Send A5, 00 01 00 00, 02 00 00 00, 13 00 00 00, 93 00 10 00 -> two DEBUG_SIG pulses, at 0x00000100 with data 0x00000013 and at 0x00000104 with data 0x00100093; then one load_done pulse; core_hold high from the cycle after A5 until DONE ends.
REQ-034 Send A5, 02 00 00 00 -> load_err=1, core_hold=0, no DEBUG_SIG pulses; then send A5 -> load_err clears.
REQ-035 Send A5, addr 0, count 00 00 00 00 -> load_done pulses 1 cycle after the last count byte; no DEBUG_SIG pulses.
REQ-036 Send A5, count 0x00001001 -> load_err=1 and the FSM returns to IDLE.
REQ-037 Send base 0xFFFFFFFC, N=2 -> writes land at 0xFFFFFFFC and then 0x00000000.
REQ-038 Toggle rx_valid randomly within a frame, and separately assert nrst in the middle of a data word -> addresses and data are unchanged by the stalls; after the reset, all outputs are 0 and there are no spurious writes.
